// File: rtl/name_pattern_sequencer_pkg.sv
// name_pattern_sequencer_pkg: shared state encoding, character codes and glyph geometry.
package name_pattern_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, SHOW_COL, GAP} state_t;
    localparam logic [4:0] CHAR_SPACE = 5'd0;
    localparam logic [4:0] CHAR_A     = 5'd1;
    localparam logic [4:0] CHAR_Z     = 5'd26;
    localparam int GLYPH_W = 5;
    localparam int GAP_W   = 1;
    function automatic logic is_letter(input logic [4:0] code);
        return code >= CHAR_A && code <= CHAR_Z;
    endfunction
endpackage

// File: rtl/name_pattern_sequencer_glyph_rom.sv
// glyph_rom: combinational 5x7 font, A..Z; every other code is blank.
//   code : character code (1..26 = A..Z)
//   col  : glyph column 0..4 (5..7 read as blank)
//   bits : column bitmap, bit0 = top row, bit7 always 0
module glyph_rom
    import name_pattern_sequencer_pkg::*;
(
    input  logic [4:0] code,
    input  logic [2:0] col,
    output logic [7:0] bits
);
    logic [39:0] cols;
    logic [63:0] padded;
    always_comb begin
        case (code)
            5'd1:    cols = 40'h7E_11_11_11_7E;
            5'd2:    cols = 40'h7F_49_49_49_36;
            5'd3:    cols = 40'h3E_41_41_41_22;
            5'd4:    cols = 40'h7F_41_41_22_1C;
            5'd5:    cols = 40'h7F_49_49_49_41;
            5'd6:    cols = 40'h7F_09_09_09_01;
            5'd7:    cols = 40'h3E_41_49_49_7A;
            5'd8:    cols = 40'h7F_08_08_08_7F;
            5'd9:    cols = 40'h00_41_7F_41_00;
            5'd10:   cols = 40'h20_40_41_3F_01;
            5'd11:   cols = 40'h7F_08_14_22_41;
            5'd12:   cols = 40'h7F_40_40_40_40;
            5'd13:   cols = 40'h7F_02_0C_02_7F;
            5'd14:   cols = 40'h7F_04_08_10_7F;
            5'd15:   cols = 40'h3E_41_41_41_3E;
            5'd16:   cols = 40'h7F_09_09_09_06;
            5'd17:   cols = 40'h3E_41_51_21_5E;
            5'd18:   cols = 40'h7F_09_19_29_46;
            5'd19:   cols = 40'h46_49_49_49_31;
            5'd20:   cols = 40'h01_01_7F_01_01;
            5'd21:   cols = 40'h3F_40_40_40_3F;
            5'd22:   cols = 40'h1F_20_40_20_1F;
            5'd23:   cols = 40'h3F_40_38_40_3F;
            5'd24:   cols = 40'h63_14_08_14_63;
            5'd25:   cols = 40'h07_08_70_08_07;
            5'd26:   cols = 40'h61_51_49_45_43;
            default: cols = 40'h0;
        endcase
        // column 0 sits in the top byte; padding makes columns 5..7 read as zero
        padded = {cols, 24'h0};
        bits = is_letter(code) ? padded[{3'd7 - col, 3'b000} +: 8] : 8'h00;
    end
endmodule

// File: rtl/name_pattern_sequencer.sv
// name_pattern_sequencer: scans a stored name out as 5x7 glyph columns with a blank gap column.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en/addr/char : character buffer write port (accepted in any state)
//   name_len, loop  : frame length and repeat mode, sampled on an accepted start
//   start, stop     : begin a frame / abort (stop wins)
//   column_pattern  : registered column bitmap, bit0 = top row
//   busy, done      : frame in progress / end-of-frame pulse
module name_pattern_sequencer
    import name_pattern_sequencer_pkg::*;
#(
    parameter int MAX_CHARS = 16,
    parameter int COL_TICKS = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_char,
    input  logic [4:0] name_len,
    input  logic       loop,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] column_pattern,
    output logic       busy,
    output logic       done
);
    localparam int IW = MAX_CHARS > 1 ? $clog2(MAX_CHARS) : 1;
    localparam int TW = COL_TICKS > 1 ? $clog2(COL_TICKS) : 1;
    state_t        state;
    logic [4:0]    chars [MAX_CHARS];
    logic [IW-1:0] idx, fetch_idx;
    logic [2:0]    col, fetch_col;
    logic [TW-1:0] tick;
    logic [4:0]    len_q, start_len;
    logic          loop_q, tick_end, last, wr_ok;
    logic [7:0]    glyph;
    // the ROM is always addressed with the column that the next boundary will show
    always_comb begin
        start_len = 32'(name_len) > MAX_CHARS ? 5'(MAX_CHARS) : name_len;
        tick_end = tick == TW'(COL_TICKS - 1);
        last = 32'(idx) + 1 >= 32'(len_q);
        fetch_idx = state == SHOW_COL ? idx : (state == GAP && !last) ? idx + IW'(1) : '0;
        fetch_col = state == SHOW_COL ? col + 3'd1 : 3'd0;
        wr_ok = 32'(wr_addr) < MAX_CHARS;
    end
    glyph_rom u_rom (
        .code(chars[fetch_idx]),
        .col (fetch_col),
        .bits(glyph)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_CHARS; i++) chars[i] <= CHAR_SPACE;
        end else if (wr_en && wr_ok) begin
            chars[IW'(wr_addr)] <= wr_char;
        end
    end
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst || stop) begin
            state <= IDLE;
            idx <= '0;
            col <= '0;
            tick <= '0;
            column_pattern <= 8'h00;
            busy <= 1'b0;
            if (rst) begin
                len_q <= '0;
                loop_q <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start && start_len != 5'd0) begin
                        state <= SHOW_COL;
                        idx <= '0;
                        col <= '0;
                        tick <= '0;
                        len_q <= start_len;
                        loop_q <= loop;
                        column_pattern <= glyph;
                        busy <= 1'b1;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                SHOW_COL: begin
                    if (!tick_end) begin
                        tick <= tick + TW'(1);
                    end else if (col == 3'(GLYPH_W - 1)) begin
                        tick <= '0;
                        state <= GAP;
                        col <= '0;
                        column_pattern <= 8'h00;
                    end else begin
                        tick <= '0;
                        col <= fetch_col;
                        column_pattern <= glyph;
                    end
                end
                GAP: begin
                    if (!tick_end) begin
                        tick <= tick + TW'(1);
                    end else if (col != 3'(GAP_W - 1)) begin
                        tick <= '0;
                        col <= col + 3'd1;
                    end else if (last && !loop_q) begin
                        tick <= '0;
                        state <= IDLE;
                        idx <= '0;
                        col <= '0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        tick <= '0;
                        state <= SHOW_COL;
                        idx <= fetch_idx;
                        col <= '0;
                        column_pattern <= glyph;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_name_pattern_sequencer.sv
// tb_name_pattern_sequencer: directed and random stimulus against a frame-position reference model.
module tb_name_pattern_sequencer;
    localparam int CT = 2;
    localparam int MC = 16;
    logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, loop = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [4:0] wr_char = 5'd0, name_len = 5'd0;
    logic [7:0] column_pattern;
    logic busy, done;
    int checks = 0, errors = 0;
    logic [4:0] mbuf [MC];
    logic [7:0] exp_pat = 8'h00;
    logic exp_busy = 1'b0, exp_done = 1'b0;
    bit active = 1'b0, mloop = 1'b0;
    int pos = 0, mlen = 0;
    logic [4:0] codes [7] = '{5'd0, 5'd1, 5'd8, 5'd9, 5'd15, 5'd27, 5'd31};
    logic [7:0] lit_a [12] = '{8'h7E, 8'h7E, 8'h11, 8'h11, 8'h11, 8'h11,
                               8'h11, 8'h11, 8'h7E, 8'h7E, 8'h00, 8'h00};

    name_pattern_sequencer #(.MAX_CHARS(MC), .COL_TICKS(CT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .name_len(name_len), .loop(loop), .start(start), .stop(stop),
        .column_pattern(column_pattern), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] font(input logic [4:0] code, input int c);
        case (code)
            5'd1:    return (c == 0 || c == 4) ? 8'h7E : 8'h11;
            5'd8:    return (c == 0 || c == 4) ? 8'h7F : 8'h08;
            5'd9:    return c == 2 ? 8'h7F : (c == 1 || c == 3) ? 8'h41 : 8'h00;
            5'd15:   return (c == 0 || c == 4) ? 8'h3E : 8'h41;
            default: return 8'h00;
        endcase
    endfunction

    // Frame viewed as a flat timeline: pos counts cycles since start, each character spans
    // 6*CT cycles (5 glyph columns + 1 gap), and the shown column is refetched every CT cycles.
    task automatic model_step();
        exp_done = 1'b0;
        if (rst || stop) begin
            active = 1'b0;
            exp_pat = 8'h00;
            exp_busy = 1'b0;
        end else if (!active) begin
            if (start) begin
                mlen = int'(name_len) > MC ? MC : int'(name_len);
                if (mlen == 0) exp_done = 1'b1;
                else begin
                    active = 1'b1;
                    pos = 0;
                    mloop = loop;
                    exp_pat = font(mbuf[0], 0);
                    exp_busy = 1'b1;
                end
            end
        end else begin
            pos++;
            if (pos == mlen * 6 * CT) begin
                if (mloop) pos = 0;
                else begin
                    active = 1'b0;
                    exp_busy = 1'b0;
                    exp_pat = 8'h00;
                    exp_done = 1'b1;
                end
            end
            if (active && pos % CT == 0)
                exp_pat = ((pos / CT) % 6) < 5 ? font(mbuf[pos / (6 * CT)], (pos / CT) % 6) : 8'h00;
        end
        if (rst) begin
            for (int i = 0; i < MC; i++) mbuf[i] = 5'd0;
        end else if (wr_en && int'(wr_addr) < MC) begin
            mbuf[wr_addr] = wr_char;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("pattern", column_pattern, exp_pat);
        chk("busy", {7'd0, busy}, {7'd0, exp_busy});
        chk("done", {7'd0, done}, {7'd0, exp_done});
        start = 1'b0;
        stop = 1'b0;
        wr_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int addr, input logic [4:0] ch);
        wr_en = 1'b1;
        wr_addr = 4'(addr);
        wr_char = ch;
        cycle();
    endtask

    task automatic go(input logic [4:0] len, input logic lp);
        start = 1'b1;
        name_len = len;
        loop = lp;
        cycle();
    endtask

    initial begin
        run(2);
        chk("reset_pattern", column_pattern, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        // single A, no loop
        wr(0, 5'd1);
        go(5'd1, 1'b0);
        chk("a_seq", column_pattern, lit_a[0]);
        for (int i = 1; i < 12; i++) begin
            cycle();
            chk("a_seq", column_pattern, lit_a[i]);
        end
        cycle();
        chk("a_done", {7'd0, done}, 8'd1);
        chk("a_busy_fall", {7'd0, busy}, 8'd0);
        cycle();
        chk("a_done_one_cycle", {7'd0, done}, 8'd0);
        // "IA" looping, then stop mid-column of character 1
        wr(0, 5'd9);
        wr(1, 5'd1);
        go(5'd2, 1'b1);
        for (int i = 1; i < 48; i++) begin
            cycle();
            if (i == 26) chk("loop_wrap_i_col1", column_pattern, 8'h41);
            if (i == 36) chk("loop_a_col0", column_pattern, 8'h7E);
        end
        run(17);
        stop = 1'b1;
        cycle();
        chk("stop_pattern", column_pattern, 8'h00);
        chk("stop_busy", {7'd0, busy}, 8'd0);
        chk("stop_no_done", {7'd0, done}, 8'd0);
        // zero length and clamped length
        go(5'd0, 1'b0);
        chk("len0_done", {7'd0, done}, 8'd1);
        chk("len0_busy", {7'd0, busy}, 8'd0);
        cycle();
        for (int i = 0; i < MC; i++) wr(i, codes[$urandom_range(0, 6)]);
        go(5'd31, 1'b0);
        run(16 * 6 * CT - 1);
        chk("clamp_still_busy", {7'd0, busy}, 8'd1);
        cycle();
        chk("clamp_done", {7'd0, done}, 8'd1);
        // rewrite displayed slot during A column 2
        wr(0, 5'd1);
        go(5'd1, 1'b0);
        run(4);
        wr(0, 5'd9);
        cycle();
        chk("rewrite_col3", column_pattern, 8'h41);
        run(7);
        // reset during gap, then blank frame
        wr(1, 5'd15);
        go(5'd2, 1'b0);
        run(10);
        rst = 1'b1;
        cycle();
        chk("rst_gap_pattern", column_pattern, 8'h00);
        chk("rst_gap_busy", {7'd0, busy}, 8'd0);
        go(5'd2, 1'b0);
        chk("blank_after_rst", column_pattern, 8'h00);
        run(2 * 6 * CT - 1);
        cycle();
        chk("blank_done", {7'd0, done}, 8'd1);
        // random traffic
        repeat (600) begin
            wr_en = $urandom_range(0, 3) == 0;
            wr_addr = 4'($urandom_range(0, 15));
            wr_char = codes[$urandom_range(0, 6)];
            start = $urandom_range(0, 15) == 0;
            name_len = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            loop = $urandom_range(0, 2) == 0;
            stop = $urandom_range(0, 80) == 0;
            rst = $urandom_range(0, 250) == 0;
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
